mem_port: RTL
=============

MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max bus-phase wait before error.
REQ-002 SHALL have clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  in  1  upstream request present.
REQ-005 SHALL have req_ready_o  out  1  request accepted when valid & ready.
REQ-006 SHALL have req_we_i  in  1  1 = store, 0 = load.
REQ-007 SHALL have req_adr_i  in  `ADR_WIDTH  byte address.
REQ-008 SHALL have req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-009 SHALL have req_dat_i  in  `DAT_WIDTH  store data, right-aligned.
REQ-010 SHALL have rsp_valid_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have rsp_dat_o  out  `DAT_WIDTH  load data, right-aligned, zero-extended.
REQ-012 SHALL have rsp_err_o  out  1  qualifies rsp_valid_o as failed.
REQ-013 SHALL have Wishbone master port mem_adr_o, mem_dat_o, mem_dat_i, mem_we_o, mem_cyc_o, mem_stb_o, mem_ack_i, mem_err_i, matching the RAM slave port.

Function
REQ-014 SHALL present byte-granular upstream accesses to a word-only (8-byte) slave; little-endian, byte n at bits [8n+7:8n].
REQ-015 SHALL drive mem_adr_o = req_adr_i with low 3 bits cleared.
REQ-016 SHALL reject misaligned requests (adr mod 2^size != 0) with rsp_valid_o & rsp_err_o in the cycle after acceptance, no bus cycle.
REQ-017 SHALL have states IDLE, RD, GAP, WR, RESP; req_ready_o = 1 only in IDLE.
REQ-018 Load: IDLE -> RD -> RESP; RD holds cyc/stb high, we low, until ack, err or timeout.
REQ-019 Dword store: IDLE -> WR -> RESP; mem_dat_o = req_dat_i.
REQ-020 Sub-dword store: IDLE -> RD -> GAP -> WR -> RESP; WR data = read word with addressed lanes replaced by low bytes of req_dat_i.
REQ-021 GAP SHALL hold stb low exactly one cycle so the slave returns to idle before the next phase.
REQ-022 SHALL latch request fields at acceptance; upstream inputs are don't-care until rsp_valid_o.
REQ-023 SHALL capture mem_dat_i on the edge where ack is sampled high in RD.
REQ-024 RESP SHALL last one cycle with stb low, then return to IDLE.
REQ-025 mem_err_i, or TIMEOUT_CYCLES cycles in RD/WR without ack, SHALL go to RESP with rsp_err_o = 1 and abort any pending write.
REQ-026 ack and err sampled together SHALL be treated as err.
REQ-027 Timeout counter SHALL reset on entry to each of RD and WR, saturating width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-028 With a 1-cycle-ack slave: load rsp 3 cycles after acceptance, dword store 3, sub-dword store 6.

Reset
REQ-029 Reset assertion SHALL immediately force state IDLE and req_ready_o 1, with mem_cyc_o, mem_stb_o, mem_we_o, rsp_valid_o, rsp_err_o 0, and mem_adr_o, mem_dat_o, rsp_dat_o 0.
REQ-030 Reset mid-transaction SHALL drop the transaction with no response issued; a partially performed RMW is not completed.
REQ-031 First request SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-032 Size encodings and state encodings SHALL be shared defines in config.v, alongside `ADR_WIDTH/`DAT_WIDTH.
REQ-033 Lane extract/merge SHALL be one combinational sub-module, mem_lane (size, offset, word, data -> extracted, merged).

Verification
REQ-034 Store dword 0x1122334455667788 @0x10, load dword @0x10 -> rsp_dat 0x1122334455667788, err 0, latencies 3/3.
REQ-035 Preload 0xFFFFFFFFFFFFFFFF @0x18, store byte 0xAB @0x1B -> word 0xFFFFFFFFABFFFFFF; load half @0x1A -> 0xABFF; store latency 6.
REQ-036 Load word @0x06 -> rsp_err 1 next cycle, mem_stb_o never asserted.
REQ-037 Load @0x400 to 128-word RAM (slave err) -> rsp_err 1; store half @0x400 -> err, no WR phase.
REQ-038 Non-responding slave, TIMEOUT_CYCLES=4 -> rsp_err 1 after 4 stb cycles; rst_i low during RD -> stb 0 same cycle, no rsp_valid.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared widths, access-size and FSM state encodings for the memory port.
// No logic; types and one helper only.
// Imported by mem_port and mem_lane.
package mem_port_pkg;

    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 64;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Request fields held for the life of one transaction.
    typedef struct packed {
        logic                 we;
        logic [2:0]           off;
        size_e                size;
        logic [DAT_WIDTH-1:0] dat;
    } req_t;

    // An access is misaligned when any address bit below its size is set.
    function automatic logic is_misaligned(input logic [2:0] off, input size_e size);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return |off[1:0];
            default:   return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane extract (load) and merge (sub-dword store) for an 8-byte word.
// Purely combinational, zero latency.
// No flow control.
module mem_lane
    import mem_port_pkg::*;
(
    input  size_e                size,
    input  logic [2:0]           offset,
    input  logic [DAT_WIDTH-1:0] word,
    input  logic [DAT_WIDTH-1:0] data,
    output logic [DAT_WIDTH-1:0] extracted,
    output logic [DAT_WIDTH-1:0] merged
);

    logic [7:0]           base_en;
    logic [7:0]           lane_en;
    logic [DAT_WIDTH-1:0] bit_en;
    logic [DAT_WIDTH-1:0] shifted;

    // Build the addressed lane mask, then pull the field down or push data up into it.
    always_comb begin
        base_en   = 8'h00;
        lane_en   = 8'h00;
        bit_en    = '0;
        shifted   = '0;
        extracted = '0;
        merged    = '0;

        case (size)
            SIZE_BYTE: base_en = 8'h01;
            SIZE_HALF: base_en = 8'h03;
            SIZE_WORD: base_en = 8'h0F;
            default:   base_en = 8'hFF;
        endcase
        lane_en = base_en << offset;
        for (int b = 0; b < 8; b++) begin
            bit_en[8*b +: 8] = {8{lane_en[b]}};
        end

        shifted = word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: extracted = {56'b0, shifted[7:0]};
            SIZE_HALF: extracted = {48'b0, shifted[15:0]};
            SIZE_WORD: extracted = {32'b0, shifted[31:0]};
            default:   extracted = shifted;
        endcase

        merged = (word & ~bit_en) | ((data << {offset, 3'b000}) & bit_en);
    end

endmodule

// File: rtl/mem_port.sv
// Byte-granular load/store front end onto an 8-byte-word Wishbone slave (RMW for sub-dword stores).
// Latency with 1-cycle-ack slave: load 3, dword store 3, sub-dword store 6, misaligned 1.
// One transaction in flight; req_ready_o high only in IDLE, slave stalls extend RD/WR up to a timeout.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADR_WIDTH-1:0] req_adr_i,
    input  logic [1:0]           req_size_i,
    input  logic [DAT_WIDTH-1:0] req_dat_i,
    output logic                 rsp_valid_o,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADR_WIDTH-1:0] mem_adr_o,
    output logic [DAT_WIDTH-1:0] mem_dat_o,
    input  logic [DAT_WIDTH-1:0] mem_dat_i,
    output logic                 mem_we_o,
    output logic                 mem_cyc_o,
    output logic                 mem_stb_o,
    input  logic                 mem_ack_i,
    input  logic                 mem_err_i
);

    localparam int TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_LAST = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;

    state_e               state;
    req_t                 req_q;
    logic [DAT_WIDTH-1:0] rd_word_q;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 tmo_hit;
    logic [DAT_WIDTH-1:0] lane_word;
    logic [DAT_WIDTH-1:0] lane_extracted;
    logic [DAT_WIDTH-1:0] lane_merged;
    size_e                req_size;

    assign req_size = size_e'(req_size_i);

    // Final waiting cycle of a bus phase: the next edge without ack is a timeout.
    assign tmo_hit = (tmo_cnt >= TMO_W'(TMO_LAST));

    // Loads extract straight from the bus on the ack edge; RMW merges from the captured word.
    assign lane_word = (state == ST_RD) ? mem_dat_i : rd_word_q;

    mem_lane u_lane (
        .size      (req_q.size),
        .offset    (req_q.off),
        .word      (lane_word),
        .data      (req_q.dat),
        .extracted (lane_extracted),
        .merged    (lane_merged)
    );

    // Transaction FSM; every bus and response output is registered here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            rd_word_q   <= '0;
            tmo_cnt     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
            mem_adr_o   <= '0;
            mem_dat_o   <= '0;
            mem_we_o    <= 1'b0;
            mem_cyc_o   <= 1'b0;
            mem_stb_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_q       <= '{we: req_we_i, off: req_adr_i[2:0], size: req_size, dat: req_dat_i};
                        req_ready_o <= 1'b0;
                        rsp_dat_o   <= '0;
                        tmo_cnt     <= '0;
                        if (is_misaligned(req_adr_i[2:0], req_size)) begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            mem_adr_o <= {req_adr_i[ADR_WIDTH-1:3], 3'b000};
                            mem_cyc_o <= 1'b1;
                            mem_stb_o <= 1'b1;
                            if (req_we_i && (req_size == SIZE_DWORD)) begin
                                state     <= ST_WR;
                                mem_we_o  <= 1'b1;
                                mem_dat_o <= req_dat_i;
                            end else begin
                                state    <= ST_RD;
                                mem_we_o <= 1'b0;
                            end
                        end
                    end
                end

                ST_RD: begin
                    // err wins over a simultaneous ack
                    if (mem_err_i || (!mem_ack_i && tmo_hit)) begin
                        state       <= ST_RESP;
                        mem_cyc_o   <= 1'b0;
                        mem_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                    end else if (mem_ack_i) begin
                        mem_stb_o <= 1'b0;
                        if (req_q.we) begin
                            // keep cyc through GAP so the RMW stays one bus tenure
                            state     <= ST_GAP;
                            rd_word_q <= mem_dat_i;
                        end else begin
                            state       <= ST_RESP;
                            mem_cyc_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_dat_o   <= lane_extracted;
                        end
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    state     <= ST_WR;
                    mem_stb_o <= 1'b1;
                    mem_we_o  <= 1'b1;
                    mem_dat_o <= lane_merged;
                    tmo_cnt   <= '0;
                end

                ST_WR: begin
                    if (mem_err_i || mem_ack_i || tmo_hit) begin
                        state       <= ST_RESP;
                        mem_cyc_o   <= 1'b0;
                        mem_stb_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= mem_err_i || !mem_ack_i;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    state       <= ST_IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                end

                default: begin
                    state       <= ST_IDLE;
                    mem_cyc_o   <= 1'b0;
                    mem_stb_o   <= 1'b0;
                    mem_we_o    <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
